// File: rtl/fll_bus_responder_pkg.sv
// fll_bus_pkg: register map, FSM states and STATUS layout for the FLL bus responder
package fll_bus_pkg;
    localparam logic [3:0] FLL_STATUS = 4'h0;
    localparam logic [3:0] FLL_CFG1   = 4'h1;
    localparam logic [3:0] FLL_CFG2   = 4'h2;
    localparam logic [3:0] FLL_INTEG  = 4'h3;
    localparam int         LOCK_BIT   = 0;
    typedef enum logic [1:0] {IDLE, WAIT, ACK} state_e;
endpackage

// File: rtl/fll_bus_responder_if.sv
// fll_bus_responder_if: FLL control-bus request/ack signals
interface fll_bus_responder_if;
    logic        req;
    logic        web;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic        ack;
    logic [31:0] rdata;
    modport master (output req, web, addr, wdata, input ack, rdata);
    modport slave (input req, web, addr, wdata, output ack, rdata);
endinterface

// File: rtl/fll_bus_responder_lock_model.sv
// fll_lock_model: lock countdown, restarted and unlocked by each load strobe
module fll_lock_model #(
    parameter int LockCycles = 16
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic load_i,
    output logic lock_o
);
    localparam logic [15:0] LOAD = 16'(LockCycles);
    logic [15:0] cnt_q, cnt_d;
    logic        lock_q, lock_d;
    always_comb begin
        cnt_d  = load_i ? LOAD : (cnt_q != 16'd0 ? cnt_q - 16'd1 : cnt_q);
        lock_d = load_i ? 1'b0 : (lock_q | (cnt_q == 16'd1));
    end
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q  <= LOAD;
            lock_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            lock_q <= lock_d;
        end
    end
    assign lock_o = lock_q;
endmodule

// File: rtl/fll_bus_responder.sv
// fll_bus_responder: FLL bus responder with CFG1/CFG2/INTEG registers and lock model
module fll_bus_responder
    import fll_bus_pkg::*;
#(
    parameter int AckLatency = 2,
    parameter int LockCycles = 16
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    fll_bus_responder_if.slave bus,
    output logic [31:0]        cfg1_o,
    output logic [31:0]        cfg2_o,
    output logic [31:0]        integ_o,
    output logic               lock_o
);
    localparam logic [3:0] CNT_INIT = 4'(AckLatency - 1);
    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d, addr_q, addr_d, addr_c;
    logic        web_q, web_d, web_c, ack_q, ack_d, start, wr, load;
    logic [31:0] wdata_q, wdata_d, wdata_c, rd_val;
    logic [31:0] cfg1_q, cfg1_d, cfg2_q, cfg2_d, integ_q, integ_d, rdata_q, rdata_d;
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end
    always_comb begin
        start   = state_q == IDLE && bus.req;
        state_d = state_q == IDLE ? (bus.req ? (AckLatency == 1 ? ACK : WAIT) : IDLE) :
                  state_q == WAIT ? (cnt_q == 4'd1 ? ACK : WAIT) : IDLE;
        cnt_d   = start ? CNT_INIT : (state_q == WAIT ? cnt_q - 4'd1 : cnt_q);
    end
    // with AckLatency = 1 the commit edge is also the capture edge, so bypass the capture flops
    always_comb begin
        addr_c  = state_q == IDLE ? bus.addr : addr_q;
        web_c   = state_q == IDLE ? bus.web : web_q;
        wdata_c = state_q == IDLE ? bus.wdata : wdata_q;
        addr_d  = start ? bus.addr : addr_q;
        web_d   = start ? bus.web : web_q;
        wdata_d = start ? bus.wdata : wdata_q;
        wr      = state_d == ACK && !web_c;
        load    = wr && addr_c == FLL_CFG1;
        cfg1_d  = load ? wdata_c : cfg1_q;
        cfg2_d  = wr && addr_c == FLL_CFG2 ? wdata_c : cfg2_q;
        integ_d = wr && addr_c == FLL_INTEG ? wdata_c : integ_q;
        rd_val  = addr_c == FLL_STATUS ? (32'(lock_o) << LOCK_BIT) :
                  addr_c == FLL_CFG1 ? cfg1_q :
                  addr_c == FLL_CFG2 ? cfg2_q :
                  addr_c == FLL_INTEG ? integ_q : 32'd0;
        ack_d   = state_d == ACK;
        rdata_d = state_d == ACK && web_c ? rd_val : 32'd0;
    end
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            addr_q  <= 4'd0;
            web_q   <= 1'b0;
            wdata_q <= 32'd0;
            cfg1_q  <= 32'd0;
            cfg2_q  <= 32'd0;
            integ_q <= 32'd0;
            ack_q   <= 1'b0;
            rdata_q <= 32'd0;
        end else begin
            addr_q  <= addr_d;
            web_q   <= web_d;
            wdata_q <= wdata_d;
            cfg1_q  <= cfg1_d;
            cfg2_q  <= cfg2_d;
            integ_q <= integ_d;
            ack_q   <= ack_d;
            rdata_q <= rdata_d;
        end
    end
    fll_lock_model #(.LockCycles(LockCycles)) u_lock (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .load_i (load),
        .lock_o (lock_o)
    );
    assign bus.ack   = ack_q;
    assign bus.rdata = rdata_q;
    assign cfg1_o    = cfg1_q;
    assign cfg2_o    = cfg2_q;
    assign integ_o   = integ_q;
endmodule

// File: tb/tb_fll_bus_responder.sv
// tb_fll_bus_responder: scoreboard bench over three responders with AckLatency 2, 1 and 4
module tb_fll_bus_responder;
    import fll_bus_pkg::*;
    localparam int LAT [3] = '{2, 1, 4};
    typedef struct {
        int          k;
        int          cyc;
        logic [31:0] rdata;
    } exp_t;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    int          cyc = 0;
    int          n_chk = 0;
    int          n_fail = 0;
    int          last_ack = 0;
    int          a1, a2;
    exp_t        sb[$];
    exp_t        mon_e;
    logic        req [3];
    logic        web [3];
    logic [3:0]  addr [3];
    logic [31:0] wdata [3];
    logic        ack [3];
    logic [31:0] rdata [3];
    logic [31:0] cfg1 [3];
    logic [31:0] cfg2 [3];
    logic [31:0] integ [3];
    logic        lock [3];
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    for (genvar g = 0; g < 3; g++) begin : gd
        fll_bus_responder_if bus();
        assign bus.req   = req[g];
        assign bus.web   = web[g];
        assign bus.addr  = addr[g];
        assign bus.wdata = wdata[g];
        assign ack[g]    = bus.ack;
        assign rdata[g]  = bus.rdata;
        fll_bus_responder #(.AckLatency(LAT[g]), .LockCycles(16)) dut (
            .clk_i   (clk),
            .rst_ni  (rst_n),
            .bus     (bus.slave),
            .cfg1_o  (cfg1[g]),
            .cfg2_o  (cfg2[g]),
            .integ_o (integ[g]),
            .lock_o  (lock[g])
        );
    end
    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (ack[k]) begin
                if (sb.size() == 0) check("spurious_ack", 32'(k), 32'hFFFF_FFFF);
                else begin
                    mon_e = sb.pop_front();
                    check("ack_dut", 32'(k), 32'(mon_e.k));
                    check("ack_cycle", 32'(cyc), 32'(mon_e.cyc));
                    check("ack_rdata", rdata[k], mon_e.rdata);
                end
            end else check("rdata_idle", rdata[k], 32'd0);
        end
    end
    task automatic txn(int k, logic w, logic [3:0] a, logic [31:0] d, logic [31:0] exp, bit drop = 1'b0);
        int n = 0;
        sb.push_back('{k, cyc + LAT[k], exp});
        req[k]   = 1'b1;
        web[k]   = w;
        addr[k]  = a;
        wdata[k] = d;
        if (drop) begin
            @(negedge clk);
            req[k]   = 1'b0;
            addr[k]  = FLL_INTEG;
            wdata[k] = ~d;
        end
        do begin
            @(negedge clk);
            n++;
        end while (!ack[k] && n < 40);
        if (!ack[k]) check("ack_timeout", 32'd0, 32'd1);
        last_ack = cyc;
        req[k] = 1'b0;
        @(negedge clk);
    endtask
    task automatic wait_cyc(int t);
        while (cyc < t) @(negedge clk);
    endtask
    initial begin
        for (int k = 0; k < 3; k++) begin
            req[k]   = 1'b0;
            web[k]   = 1'b1;
            addr[k]  = 4'h0;
            wdata[k] = 32'd0;
        end
        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            check("rst_ack", 32'(ack[k]), 32'd0);
            check("rst_cfg1", cfg1[k], 32'd0);
            check("rst_cfg2", cfg2[k], 32'd0);
            check("rst_integ", integ[k], 32'd0);
            check("rst_lock", 32'(lock[k]), 32'd0);
        end
        rst_n = 1'b1;
        a1 = cyc;
        wait_cyc(a1 + 15);
        for (int k = 0; k < 3; k++) check("lock_pre", 32'(lock[k]), 32'd0);
        @(negedge clk);
        for (int k = 0; k < 3; k++) check("lock_rise", 32'(lock[k]), 32'd1);
        txn(0, 1'b0, FLL_CFG2, 32'hDEAD_BEEF, 32'd0);
        check("cfg2_wr", cfg2[0], 32'hDEAD_BEEF);
        txn(0, 1'b1, FLL_CFG2, 32'd0, 32'hDEAD_BEEF);
        txn(0, 1'b1, FLL_CFG1, 32'd0, 32'd0);
        txn(0, 1'b1, FLL_STATUS, 32'd0, 32'd1);
        txn(0, 1'b0, FLL_CFG1, 32'h1, 32'd0);
        a1 = last_ack;
        check("cfg1_wr", cfg1[0], 32'h1);
        check("unlock_on_cfg1", 32'(lock[0]), 32'd0);
        wait_cyc(a1 + 5);
        txn(0, 1'b0, FLL_CFG1, 32'h2, 32'd0);
        a2 = last_ack;
        wait_cyc(a1 + 16);
        check("lock_reloaded", 32'(lock[0]), 32'd0);
        wait_cyc(a2 + 15);
        check("lock_pre2", 32'(lock[0]), 32'd0);
        @(negedge clk);
        check("lock_rise2", 32'(lock[0]), 32'd1);
        txn(1, 1'b0, FLL_INTEG, 32'h5A5A_0003, 32'd0);
        a1 = last_ack;
        txn(1, 1'b1, FLL_STATUS, 32'd0, 32'd1);
        check("b2b_gap1", 32'(last_ack - a1), 32'd2);
        a1 = last_ack;
        txn(1, 1'b1, 4'h7, 32'd0, 32'd0);
        check("b2b_gap2", 32'(last_ack - a1), 32'd2);
        check("integ_wr", integ[1], 32'h5A5A_0003);
        txn(1, 1'b0, FLL_STATUS, 32'hFFFF_FFFF, 32'd0);
        txn(1, 1'b0, 4'h9, 32'h1111_2222, 32'd0);
        txn(1, 1'b1, FLL_STATUS, 32'd0, 32'd1);
        check("cfg1_untouched", cfg1[1], 32'd0);
        txn(2, 1'b0, FLL_CFG2, 32'h1234_5678, 32'd0, 1'b1);
        check("drop_commit", cfg2[2], 32'h1234_5678);
        check("drop_no_integ", integ[2], 32'd0);
        req[2]   = 1'b1;
        web[2]   = 1'b0;
        addr[2]  = FLL_CFG1;
        wdata[2] = 32'hCAFE_F00D;
        repeat (2) @(negedge clk);
        rst_n  = 1'b0;
        req[2] = 1'b0;
        @(negedge clk);
        check("abort_cfg1", cfg1[2], 32'd0);
        check("abort_ack", 32'(ack[2]), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        check("abort_cfg1_after", cfg1[2], 32'd0);
        check("abort_lock", 32'(lock[2]), 32'd0);
        txn(2, 1'b1, FLL_CFG1, 32'd0, 32'd0);
        repeat (4) @(negedge clk);
        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
